// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA video-RAM path.
// Frame geometry, bus widths, grant encoding and the write-request record.
package vga_pkg;
    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int FRAME_PIXELS = H_RES * V_RES;
    localparam int ADDR_W       = 19;
    localparam int DATA_W       = 8;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_READ,
        GNT_WRITE
    } grant_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;
endpackage

// File: rtl/vga_wr_fifo.sv
// 4-deep write-request FIFO carrying {addr, data}.
// Latency: an entry pushed at t is visible at the head from t+1 (no bypass).
// Backpressure: push ignored when full; full/empty come from registered occupancy.
module vga_wr_fifo
    import vga_pkg::*;
(
    input  logic    clk_50MHz,
    input  logic    clear,
    input  logic    push,
    input  wr_req_t push_dat,
    input  logic    pop,
    output wr_req_t pop_dat,
    output logic    full,
    output logic    empty
);
    wr_req_t    slots [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       push_ok;
    logic       pop_ok;

    assign full    = (count == 3'd4);
    assign empty   = (count == 3'd0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = slots[rd_ptr];

    always_ff @(posedge clk_50MHz) begin
        if (push_ok)
            slots[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk_50MHz) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 2'd1;
            count <= count + 3'(push_ok) - 3'(pop_ok);
        end
    end
endmodule

// File: rtl/vga_vram_arbiter.sv
// Arbitrates single-port VRAM between display pixel fetch and buffered drawing writes.
// Latency: read pix_en -> pix_valid 3 clocks; write handshake -> mem_we 2 clocks minimum.
// Backpressure: wr_ready drops when the 4-entry FIFO is full or clear is high; reads never stall.
module vga_vram_arbiter
    import vga_pkg::*;
(
    input  logic              clk_50MHz,
    input  logic              clear,
    input  logic              pix_en,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              bright,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              frame_start
);
    grant_t            gnt;
    wr_req_t           head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              frame_sync;
    logic              in_range;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_cur;
    logic              tag_issue;
    logic              tag_data;

    assign wr_ready   = !fifo_full && !clear;
    assign push       = wr_valid && wr_ready;
    assign frame_sync = pix_en && (h_count == 10'd0) && (v_count == 10'd0);
    // A read landing on the frame-sync pixel fetches address 0, not the stale counter.
    assign rd_cur     = frame_sync ? '0 : rd_addr;
    assign in_range   = head.addr < ADDR_W'(FRAME_PIXELS);

    always_comb begin
        gnt = GNT_NONE;
        if (pix_en && bright)
            gnt = GNT_READ;
        else if (!fifo_empty)
            gnt = GNT_WRITE;
    end

    vga_wr_fifo u_wr_fifo (
        .clk_50MHz (clk_50MHz),
        .clear     (clear),
        .push      (push),
        .push_dat  ('{addr: wr_addr, data: wr_data}),
        .pop       (gnt == GNT_WRITE),
        .pop_dat   (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_50MHz) begin
        if (clear) begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            wr_err      <= 1'b0;
            frame_start <= 1'b0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            rd_addr     <= '0;
            tag_issue   <= 1'b0;
            tag_data    <= 1'b0;
        end else begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            wr_err      <= 1'b0;
            frame_start <= frame_sync;
            tag_issue   <= 1'b0;
            tag_data    <= tag_issue;
            pix_valid   <= tag_data;
            if (tag_data)
                pix_data <= mem_rdata;

            case (gnt)
                GNT_READ: begin
                    mem_en    <= 1'b1;
                    mem_addr  <= rd_cur;
                    tag_issue <= 1'b1;
                    rd_addr   <= (rd_cur == ADDR_W'(FRAME_PIXELS - 1)) ? '0 : rd_cur + ADDR_W'(1);
                end
                GNT_WRITE: begin
                    // Out-of-range requests are consumed but never reach the RAM.
                    if (in_range) begin
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= head.addr;
                        mem_wdata <= head.data;
                    end else begin
                        wr_err <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (frame_sync && gnt != GNT_READ)
                rd_addr <= '0;
        end
    end
endmodule
